// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the MEM-stage data-memory access unit.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package mem_access_unit_pkg;

    // Access FSM encodings.
    typedef enum logic [1:0] {
        MEM_IDLE = 2'd0,
        MEM_REQ  = 2'd1,
        MEM_DONE = 2'd2
    } mem_state_t;

    localparam logic [3:0] BE_WORD = 4'hF;

    // Byte enables for an access of the given size at a byte offset.
    // Byte accesses select one little-endian lane; word accesses select all.
    function automatic logic [3:0] be_for(input logic is_byte, input logic [1:0] offset);
        logic [3:0] be;
        be = BE_WORD;
        if (is_byte) begin
            be = 4'b0001 << offset;
        end
        return be;
    endfunction

endpackage

// File: rtl/mem_access_unit_load_align.sv
// Load data aligner: picks a little-endian byte lane and sign/zero extends it.
// Latency: purely combinational.
// Backpressure: none; output follows inputs.
// Ports: rdata (raw bus word), offset (addr[1:0]), is_byte (byte vs word),
//        signextend (sign vs zero extension of byte loads), data (result).
module load_align (
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic        is_byte,
    input  logic        signextend,
    output logic [31:0] data
);

    logic [7:0] lane;

    always_comb begin
        lane = rdata[8*offset +: 8];
        data = rdata;
        if (is_byte) begin
            data = {{24{signextend & lane[7]}}, lane};
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: req/ack bus transaction with misalign and timeout errors.
// Latency: 3 cycles minimum (IDLE, REQ+ack, DONE), +1 per ack delay cycle; misaligned 2 cycles.
// Backpressure: combinational stall holds the pipeline until the DONE cycle; memory throttles via dmem_ack.
// Ports: pipeline side op_valid/mem_we/mem_read/mem_byte/mem_signextend/addr/wdata in,
//        stall/load_data/done/addr_err/bus_err out; bus side dmem_req/we/addr/be/wdata out,
//        dmem_ack/dmem_rdata in.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        op_valid,
    input  logic        mem_we,
    input  logic        mem_read,
    input  logic        mem_byte,
    input  logic        mem_signextend,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        done,
    output logic        addr_err,
    output logic        bus_err,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [29:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata
);

    localparam int              CW       = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CW-1:0]   TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

    mem_state_t    state, state_nxt;
    logic          is_mem;
    logic          misaligned;
    logic          tmo_hit;
    logic [CW-1:0] tmo_cnt;

    // Attributes of the access in flight, captured when the request is issued
    // so the aligner does not depend on the pipeline holding its inputs.
    logic          req_load;
    logic          req_byte;
    logic          req_sext;
    logic [1:0]    req_off;
    logic [31:0]   aligned_data;

    assign is_mem     = op_valid & (mem_we | mem_read);
    assign misaligned = ~mem_byte & (addr[1:0] != 2'b00);
    assign tmo_hit    = (tmo_cnt == TMO_LAST);

    load_align u_load_align (
        .rdata      (dmem_rdata),
        .offset     (req_off),
        .is_byte    (req_byte),
        .signextend (req_sext),
        .data       (aligned_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= MEM_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // The pipeline is released in DONE and advances on the edge leaving it.
    always_comb begin
        state_nxt = state;
        stall     = is_mem & (state != MEM_DONE);
        case (state)
            MEM_IDLE: begin
                if (is_mem) begin
                    state_nxt = misaligned ? MEM_DONE : MEM_REQ;
                end
            end
            MEM_REQ: begin
                if (dmem_ack || tmo_hit) begin
                    state_nxt = MEM_DONE;
                end
            end
            MEM_DONE: state_nxt = MEM_IDLE;
            default:  state_nxt = MEM_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_be    <= 4'h0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            load_data  <= '0;
            done       <= 1'b0;
            addr_err   <= 1'b0;
            bus_err    <= 1'b0;
            tmo_cnt    <= '0;
            req_load   <= 1'b0;
            req_byte   <= 1'b0;
            req_sext   <= 1'b0;
            req_off    <= 2'b00;
        end else begin
            // Completion flags are single-cycle pulses.
            done     <= 1'b0;
            addr_err <= 1'b0;
            bus_err  <= 1'b0;
            case (state)
                MEM_IDLE: begin
                    if (is_mem) begin
                        if (misaligned) begin
                            done      <= 1'b1;
                            addr_err  <= 1'b1;
                            load_data <= '0;
                        end else begin
                            dmem_req   <= 1'b1;
                            dmem_we    <= mem_we;
                            dmem_be    <= be_for(mem_byte, addr[1:0]);
                            dmem_addr  <= addr[31:2];
                            dmem_wdata <= mem_byte ? {4{wdata[7:0]}} : wdata;
                            req_load   <= ~mem_we;   // store wins when both are set
                            req_byte   <= mem_byte;
                            req_sext   <= mem_signextend;
                            req_off    <= addr[1:0];
                            tmo_cnt    <= '0;
                        end
                    end
                end
                MEM_REQ: begin
                    if (dmem_ack) begin
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                        done     <= 1'b1;
                        if (req_load) begin
                            load_data <= aligned_data;
                        end
                    end else if (tmo_hit) begin
                        dmem_req  <= 1'b0;
                        dmem_we   <= 1'b0;
                        done      <= 1'b1;
                        bus_err   <= 1'b1;
                        load_data <= '0;
                    end else begin
                        // Leaving REQ at TMO_LAST means the count never wraps.
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit: directed vectors plus randomized accesses against a behavioural model.
// Latency: n/a.
// Backpressure: bench acts as the memory, acking after a chosen number of request cycles.
module tb_mem_access_unit;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        op_valid = 1'b0, mem_we = 1'b0, mem_read = 1'b0, mem_byte = 1'b0, mem_signextend = 1'b0;
    logic [31:0] addr = '0, wdata = '0;
    logic        stall, done, addr_err, bus_err, dmem_req, dmem_we;
    logic [31:0] load_data, dmem_wdata;
    logic [29:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic        dmem_ack = 1'b0;
    logic [31:0] dmem_rdata = '0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .mem_we(mem_we), .mem_read(mem_read),
        .mem_byte(mem_byte), .mem_signextend(mem_signextend), .addr(addr), .wdata(wdata),
        .stall(stall), .load_data(load_data), .done(done), .addr_err(addr_err), .bus_err(bus_err),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
        .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata)
    );

    // Reference: value a load should return, from lane arithmetic.
    function automatic logic [31:0] model_load(input logic [31:0] rd, input logic [1:0] off,
                                               input logic bt, input logic sx);
        int unsigned v;
        if (!bt) return rd;
        v = (rd / (32'd1 << (8 * off))) % 256;
        if (sx && v >= 128) v = v + 32'hFFFFFF00;
        return v;
    endfunction

    // Runs one access; memory acks on request cycle number 'delay' (0 = first).
    task automatic run_access(input logic we, rd, bt, sx, input logic [31:0] a, wd, rdat, input int delay,
                              output int n_stall, output int n_req, output logic [3:0] o_be,
                              output logic [31:0] o_wd, output logic o_we, output logic [29:0] o_addr,
                              output logic [31:0] o_ld, output logic o_ae, output logic o_bus,
                              output logic o_done);
        n_stall = 0; n_req = 0; o_be = '0; o_wd = '0; o_we = 1'b0; o_addr = '0;
        o_ld = '0; o_ae = 1'b0; o_bus = 1'b0; o_done = 1'b0;
        @(negedge clk);
        op_valid = 1'b1; mem_we = we; mem_read = rd; mem_byte = bt; mem_signextend = sx;
        addr = a; wdata = wd;
        #1;
        for (int c = 0; c < 40; c++) begin
            if (done) begin
                o_done = 1'b1; o_ld = load_data; o_ae = addr_err; o_bus = bus_err;
                break;
            end
            if (stall) n_stall++;
            dmem_ack = 1'b0;
            if (dmem_req) begin
                if (n_req == 0) begin
                    o_be = dmem_be; o_wd = dmem_wdata; o_we = dmem_we; o_addr = dmem_addr;
                end
                if (n_req == delay) begin
                    dmem_ack = 1'b1; dmem_rdata = rdat;
                end else begin
                    dmem_rdata = $urandom;
                end
                n_req++;
            end
            @(negedge clk); #1;
        end
        dmem_ack = 1'b0; op_valid = 1'b0; mem_we = 1'b0; mem_read = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL reset_req got=%b exp=0", dmem_req); end
        checks++; if ({dmem_we, dmem_be} !== 5'h0) begin errors++; $display("FAIL reset_we_be got=%b%h exp=00", dmem_we, dmem_be); end
        checks++; if (dmem_addr !== 30'h0) begin errors++; $display("FAIL reset_addr got=%h exp=0", dmem_addr); end
        checks++; if (dmem_wdata !== 32'h0) begin errors++; $display("FAIL reset_wdata got=%h exp=0", dmem_wdata); end
        checks++; if (load_data !== 32'h0) begin errors++; $display("FAIL reset_load_data got=%h exp=0", load_data); end
        checks++; if ({done, addr_err, bus_err, stall} !== 4'b0) begin errors++; $display("FAIL reset_flags got=%b exp=0000", {done, addr_err, bus_err, stall}); end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_word_load();
        int ns, nr; logic [3:0] be; logic [31:0] wd, ld; logic we, ae, bu, dn; logic [29:0] ad;
        run_access(0, 1, 0, 0, 32'h100, 32'h0, 32'hDEADBEEF, 0, ns, nr, be, wd, we, ad, ld, ae, bu, dn);
        checks++; if (dn !== 1'b1) begin errors++; $display("FAIL word_load_done got=%b exp=1", dn); end
        checks++; if (be !== 4'hF) begin errors++; $display("FAIL word_load_be got=%h exp=f", be); end
        checks++; if (ns !== 2) begin errors++; $display("FAIL word_load_stall got=%0d exp=2", ns); end
        checks++; if (ld !== 32'hDEADBEEF) begin errors++; $display("FAIL word_load_data got=%h exp=deadbeef", ld); end
        checks++; if (ad !== 30'h40 || we !== 1'b0) begin errors++; $display("FAIL word_load_bus got=%h/%b exp=40/0", ad, we); end
        checks++; if ({ae, bu} !== 2'b00) begin errors++; $display("FAIL word_load_err got=%b exp=00", {ae, bu}); end
    endtask

    task automatic test_byte_loads();
        int ns, nr; logic [3:0] be; logic [31:0] wd, ld; logic we, ae, bu, dn; logic [29:0] ad;
        run_access(0, 1, 1, 1, 32'h103, 32'h0, 32'h80123456, 1, ns, nr, be, wd, we, ad, ld, ae, bu, dn);
        checks++; if (ld !== 32'hFFFFFF80) begin errors++; $display("FAIL byte_load_sext got=%h exp=ffffff80", ld); end
        checks++; if (be !== 4'b1000) begin errors++; $display("FAIL byte_load_be got=%b exp=1000", be); end
        checks++; if (ns !== 3) begin errors++; $display("FAIL byte_load_stall got=%0d exp=3", ns); end
        run_access(0, 1, 1, 0, 32'h103, 32'h0, 32'h80123456, 0, ns, nr, be, wd, we, ad, ld, ae, bu, dn);
        checks++; if (ld !== 32'h00000080) begin errors++; $display("FAIL byte_load_zext got=%h exp=00000080", ld); end
        // load_data must hold after the completion pulse
        @(negedge clk); @(negedge clk); #1;
        checks++; if (load_data !== 32'h00000080 || done !== 1'b0) begin errors++; $display("FAIL load_hold got=%h/%b exp=00000080/0", load_data, done); end
    endtask

    task automatic test_byte_store();
        int ns, nr; logic [3:0] be; logic [31:0] wd, ld; logic we, ae, bu, dn; logic [29:0] ad;
        run_access(1, 0, 1, 0, 32'h21, 32'h000000AB, 32'h0, 0, ns, nr, be, wd, we, ad, ld, ae, bu, dn);
        checks++; if (be !== 4'b0010) begin errors++; $display("FAIL byte_store_be got=%b exp=0010", be); end
        checks++; if (wd !== 32'hABABABAB) begin errors++; $display("FAIL byte_store_wdata got=%h exp=abababab", wd); end
        checks++; if (we !== 1'b1 || ad !== 30'h8) begin errors++; $display("FAIL byte_store_we_addr got=%b/%h exp=1/8", we, ad); end
        checks++; if (dn !== 1'b1 || nr !== 1) begin errors++; $display("FAIL byte_store_done got=%b/%0d exp=1/1", dn, nr); end
    endtask

    task automatic test_misaligned();
        int ns, nr; logic [3:0] be; logic [31:0] wd, ld; logic we, ae, bu, dn; logic [29:0] ad;
        run_access(0, 1, 0, 0, 32'h102, 32'h0, 32'h12345678, 0, ns, nr, be, wd, we, ad, ld, ae, bu, dn);
        checks++; if (nr !== 0) begin errors++; $display("FAIL misalign_req got=%0d exp=0", nr); end
        checks++; if ({dn, ae, bu} !== 3'b110) begin errors++; $display("FAIL misalign_flags got=%b exp=110", {dn, ae, bu}); end
        checks++; if (ns !== 1) begin errors++; $display("FAIL misalign_stall got=%0d exp=1", ns); end
        checks++; if (ld !== 32'h0) begin errors++; $display("FAIL misalign_data got=%h exp=0", ld); end
    endtask

    task automatic test_timeout();
        int ns, nr; logic [3:0] be; logic [31:0] wd, ld; logic we, ae, bu, dn; logic [29:0] ad;
        run_access(0, 1, 0, 0, 32'h300, 32'h0, 32'h0, 1000, ns, nr, be, wd, we, ad, ld, ae, bu, dn);
        checks++; if (nr !== TMO) begin errors++; $display("FAIL timeout_req_cycles got=%0d exp=%0d", nr, TMO); end
        checks++; if ({dn, ae, bu} !== 3'b101) begin errors++; $display("FAIL timeout_flags got=%b exp=101", {dn, ae, bu}); end
        checks++; if (ns !== TMO + 1 || ld !== 32'h0) begin errors++; $display("FAIL timeout_release got=%0d/%h exp=%0d/0", ns, ld, TMO + 1); end
    endtask

    task automatic test_non_mem();
        int bad = 0;
        @(negedge clk);
        op_valid = 1'b1; mem_we = 1'b0; mem_read = 1'b0; addr = 32'h102; dmem_ack = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            if (stall || dmem_req || done || addr_err) bad++;
            @(negedge clk);
        end
        op_valid = 1'b0; dmem_ack = 1'b0;
        checks++; if (bad !== 0) begin errors++; $display("FAIL non_mem_quiet got=%0d bad cycles exp=0", bad); end
    endtask

    task automatic test_reset_mid();
        int ns, nr, w; logic [3:0] be; logic [31:0] wd, ld; logic we, ae, bu, dn; logic [29:0] ad;
        @(negedge clk);
        op_valid = 1'b1; mem_read = 1'b1; mem_byte = 1'b0; addr = 32'h200;
        w = 0;
        while (!dmem_req && w < 10) begin @(negedge clk); w++; end
        checks++; if (dmem_req !== 1'b1) begin errors++; $display("FAIL rst_mid_req_rise got=%b exp=1", dmem_req); end
        @(negedge clk); @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({dmem_req, dmem_be, done} !== 6'b0) begin errors++; $display("FAIL rst_mid_drop got=%b exp=0", {dmem_req, dmem_be, done}); end
        @(negedge clk); op_valid = 1'b0; mem_read = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        run_access(0, 1, 0, 0, 32'h204, 32'h0, 32'hCAFEF00D, 2, ns, nr, be, wd, we, ad, ld, ae, bu, dn);
        checks++; if (dn !== 1'b1 || ld !== 32'hCAFEF00D || ns !== 4) begin errors++; $display("FAIL rst_mid_recover got=%b/%h/%0d exp=1/cafef00d/4", dn, ld, ns); end
    endtask

    task automatic test_random();
        int ns, nr, dly, xs, xr; logic [3:0] be, xbe; logic [31:0] wd, ld, a, wv, rv, xld; logic [29:0] ad;
        logic we, ae, bu, dn, owe, ord, bt, sx, mis, is_ld;
        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 2))
                0: begin owe = 0; ord = 1; end
                1: begin owe = 1; ord = 0; end
                default: begin owe = 1; ord = 1; end
            endcase
            bt = $urandom_range(0, 1); sx = $urandom_range(0, 1);
            a = $urandom; if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
            wv = $urandom; rv = $urandom; dly = $urandom_range(0, 9);
            is_ld = ord && !owe;
            mis = !bt && (a % 4 != 0);
            xbe = bt ? 4'(1 << (a % 4)) : 4'd15;
            run_access(owe, ord, bt, sx, a, wv, rv, dly, ns, nr, be, wd, we, ad, ld, ae, bu, dn);
            if (mis) begin
                xs = 1; xr = 0; xld = 0;
            end else if (dly >= TMO) begin
                xs = TMO + 1; xr = TMO; xld = 0;
            end else begin
                xs = dly + 2; xr = dly + 1; xld = model_load(rv, a[1:0], bt, sx);
            end
            checks++; if (dn !== 1'b1 || ae !== mis || bu !== (!mis && dly >= TMO)) begin errors++; $display("FAIL rnd%0d_flags got=%b%b%b mis=%b dly=%0d", i, dn, ae, bu, mis, dly); end
            checks++; if (ns !== xs || nr !== xr) begin errors++; $display("FAIL rnd%0d_cycles got=%0d/%0d exp=%0d/%0d", i, ns, nr, xs, xr); end
            if (is_ld) begin
                checks++; if (ld !== xld) begin errors++; $display("FAIL rnd%0d_load got=%h exp=%h", i, ld, xld); end
            end
            if (!mis) begin
                checks++; if (be !== xbe || we !== owe || ad !== a[31:2]) begin errors++; $display("FAIL rnd%0d_bus got=%b/%b/%h exp=%b/%b/%h", i, be, we, ad, xbe, owe, a[31:2]); end
                if (owe) begin
                    checks++; if (wd !== (bt ? (wv % 256) * 32'h01010101 : wv)) begin errors++; $display("FAIL rnd%0d_wdata got=%h", i, wd); end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_word_load();
        test_byte_loads();
        test_byte_store();
        test_misaligned();
        test_timeout();
        test_non_mem();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
